// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// port count, port-id type and a one-hot helper.
// Optional feature macro: RAM_ARB_RR_EN (round-robin arbitration).
package ram_arbiter_pkg;

    localparam int NPORT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic port_id_t;

    // Convert a port id into its one-hot strobe pattern.
    function automatic logic [NPORT-1:0] port_onehot(input port_id_t id);
        if (id == 1'b1) begin
            port_onehot = 2'b10;
        end else begin
            port_onehot = 2'b01;
        end
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for the two-port RAM arbiter.
// With RAM_ARB_RR_EN defined, contention goes to the port that was not
// granted last (ptr holds the last granted port); otherwise port 0 wins.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic [NPORT-1:0] req,
`ifdef RAM_ARB_RR_EN
    input  port_id_t         ptr,
`endif
    output logic             any_req,
    output port_id_t         win
);

    // Pick the winning port from the live request vector.
    always_comb begin
        any_req = |req;
        win     = 1'b0;
        case (req)
            2'b01: win = 1'b0;
            2'b10: win = 1'b1;
            2'b11: begin
`ifdef RAM_ARB_RR_EN
                win = ~ptr;
`else
                win = 1'b0;
`endif
            end
            default: win = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// IDLE samples requests, ACC drives one RAM access and the grant pulse,
// RESP waits for the RAM read data, which is returned with rvalid one
// cycle later. Optional macro RAM_ARB_RR_EN selects round-robin
// arbitration; the default build is fixed priority (port 0 first).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [N-1:0]     addr0,
    input  logic [N-1:0]     addr1,
    input  logic [M-1:0]     wdata0,
    input  logic [M-1:0]     wdata1,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [M-1:0]     rdata,
    output logic             ram_cs,
    output logic             ram_rd,
    output logic             ram_wr,
    output logic [N-1:0]     ram_addr,
    output logic [M-1:0]     ram_wdata,
    input  logic [M-1:0]     ram_rdata
);

    state_e       state_r;
    state_e       state_s;
    port_id_t     id_r;
    logic         we_r;
    logic         any_req_s;
    port_id_t     win_s;
    logic         sel_we_s;
    logic [N-1:0] sel_addr_s;
    logic [M-1:0] sel_wdata_s;
    logic         accept_s;

`ifdef RAM_ARB_RR_EN
    port_id_t     ptr_r;

    ram_arb_pick u_pick (
        .req     (req),
        .ptr     (ptr_r),
        .any_req (any_req_s),
        .win     (win_s)
    );
`else
    ram_arb_pick u_pick (
        .req     (req),
        .any_req (any_req_s),
        .win     (win_s)
    );
`endif

    // Route the winning port's command fields and flag a new acceptance.
    always_comb begin
        accept_s = (state_r == IDLE) && any_req_s;
        if (win_s == 1'b1) begin
            sel_we_s    = we[1];
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we[0];
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Next-state logic: requests only matter in IDLE; writes skip RESP.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s = ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (we_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register and latched winner id/direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            id_r    <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                id_r <= win_s;
                we_r <= sel_we_s;
            end
        end
    end

    // RAM strobes and grant pulse are registered so they are high exactly
    // during ACC; address/data hold their last values outside ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= 2'b00;
            ram_cs    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= {N{1'b0}};
            ram_wdata <= {M{1'b0}};
        end else if (accept_s) begin
            gnt       <= port_onehot(win_s);
            ram_cs    <= 1'b1;
            ram_rd    <= ~sel_we_s;
            ram_wr    <= sel_we_s;
            ram_addr  <= sel_addr_s;
            ram_wdata <= sel_wdata_s;
        end else begin
            gnt       <= 2'b00;
            ram_cs    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
        end
    end

    // Capture RAM read data at the end of RESP and pulse rvalid next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= {M{1'b0}};
            rvalid <= 2'b00;
        end else if (state_r == RESP) begin
            rdata  <= ram_rdata;
            rvalid <= port_onehot(id_r);
        end else begin
            rvalid <= 2'b00;
        end
    end

`ifdef RAM_ARB_RR_EN
    // Remember the last granted port; reset value makes port 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 1'b1;
        end else if (accept_s) begin
            ptr_r <= win_s;
        end
    end
`endif

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter M, default 8, data width in bits.
REQ-002 Parameter N, default 8, address width in bits (2**N words).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-port request, bit i for port i; held high until gnt[i].
REQ-006 we  input  2  per-port direction: 1 = write, 0 = read; stable while req[i] high.
REQ-007 addr0, addr1  input  N  per-port word address; stable while req[i] high.
REQ-008 wdata0, wdata1  input  M  per-port write data; stable while req[i] high.
REQ-009 gnt  output  2  one-cycle acceptance pulse per port.
REQ-010 rvalid  output  2  one-cycle read-data-valid pulse per port.
REQ-011 rdata  output  M  read data, shared by both ports, qualified by rvalid.
REQ-012 ram_cs, ram_rd, ram_wr  output  1 each  RAM strobes.
REQ-013 ram_addr  output  N; ram_wdata  output  M; ram_rdata  input  M (RAM data_out, valid one cycle after ram_rd).

Function
REQ-014 FSM states: IDLE, ACC, RESP.
- IDLE: req sampled at clock edge; if any req bit set -> ACC, winner latched (id, we, addr, wdata).
- ACC: one cycle; gnt[id]=1, ram_cs=1, ram_rd=~we_l, ram_wr=we_l, ram_addr/ram_wdata from latch. Read -> RESP; write -> IDLE.
- RESP: one cycle; ram_rdata captured into rdata at end of cycle; next cycle rvalid[id]=1; -> IDLE.
REQ-015 Latency, req sampled at edge ending cycle T: gnt and RAM strobe in T+1; read rvalid in T+3. Throughput: one write per 2 cycles, one read per 3 cycles.
REQ-016 req is ignored in ACC and RESP; it is sampled only in IDLE.
REQ-017 ram_cs is never high without exactly one of ram_rd/ram_wr; ram_rd and ram_wr are never high together. This prevents the RAM entering its high-impedance output path.
REQ-018 Outside ACC: ram_cs=ram_rd=ram_wr=0, and ram_addr/ram_wdata hold their last values.
REQ-019 gnt and rvalid are each one-hot or zero; rdata holds its value until the next read capture.
REQ-020 When rvalid is asserted in cycle T+3, the FSM is in IDLE and may accept a new request at the same edge.
REQ-021 Single requester: that port always wins, regardless of arbitration mode.

Reset
REQ-022 rst_n low immediately forces:
- state=IDLE; gnt=0, rvalid=0, rdata=0;
- ram_cs=ram_rd=ram_wr=0, ram_addr=0, ram_wdata=0;
- round-robin pointer=port 1 (so port 0 wins the first contention).
REQ-023 Reset during ACC or RESP aborts the transaction: no gnt or rvalid follows, and the requester re-requests.

Configuration
REQ-024 Macro RAM_ARB_RR_EN defined: on contention, the port not granted last wins; the pointer updates on every grant.
REQ-025 RAM_ARB_RR_EN undefined: fixed priority, port 0 always wins contention; no pointer register exists.

Structure
REQ-026 Shared package holds:
- the state enum (IDLE, ACC, RESP);
- port-count constant NPORT=2;
- port-id typedef.
REQ-027 One sub-module, ram_arb_pick: combinational winner selection from req plus pointer (pointer unused in fixed mode).
REQ-028 The RAM is instantiated outside this block; ram_* ports connect directly to its cs/rd/wr/addr/data_in/data_out.

Verification
REQ-029 Port 0 write, addr 0x10, data 0xA5; then port 0 read of 0x10 -> gnt[0] at T+1, rvalid[0] at T+3 with rdata=0xA5.
REQ-030 Both ports request reads (addr 0x01 / 0x02, preloaded 0x11 / 0x22):
- RR_EN: grants port 0 then port 1; rdata 0x11 then 0x22.
- Fixed mode, port 0 held requesting: port 1 never granted.
REQ-031 Back-to-back writes by port 1 to addrs 0x00..0x03 -> gnt[1] every 2 cycles; ram_wr never overlaps ram_rd.
REQ-032 rst_n pulsed low during RESP of a read -> no rvalid; all outputs 0; next request served normally.
REQ-033 Address wrap: write 0xFF (N=8) with 0x5A, read 0xFF -> 0x5A; addr 0x00 unaffected.
REQ-034 Assertion over all tests: ram_cs implies (ram_rd XOR ram_wr); gnt and rvalid are one-hot or zero.
